// File: rtl/qed_i_cache_pkg.sv
// Shared QED definitions: instruction width, the NOP filler word and the phase encoding.
package qed_i_cache_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] QED_NOP = 32'h00000013;

  typedef enum logic {
    MODE_ORIG = 1'b0,
    MODE_DUP  = 1'b1
  } qed_mode_e;
endpackage

// File: rtl/qed_i_cache_if.sv
// Fetch-side inputs and decoder-side outputs of the QED instruction replay buffer.
interface qed_i_cache_if #(parameter int DEPTH = 16);
  import qed_i_cache_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic               ena;
  logic               exec_dup;
  logic               stall;
  logic               ifu_vld;
  logic [INSTR_W-1:0] ifu_qed_instruction;
  logic [INSTR_W-1:0] qic_qimux_instruction;
  logic               qic_vld_out;
  logic               qic_empty;
  logic               qic_full;
  logic [CW-1:0]      qic_count;
  logic               qic_overflow;

  modport master (
    output ena, exec_dup, stall, ifu_vld, ifu_qed_instruction,
    input  qic_qimux_instruction, qic_vld_out, qic_empty, qic_full, qic_count, qic_overflow
  );
  modport slave (
    input  ena, exec_dup, stall, ifu_vld, ifu_qed_instruction,
    output qic_qimux_instruction, qic_vld_out, qic_empty, qic_full, qic_count, qic_overflow
  );
endinterface

// File: rtl/qed_i_cache_fifo.sv
// Generic synchronous FIFO with registered count/flags and a synchronous flush.
module qed_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             do_push, do_pop;

  // Push has precedence only nominally; callers never assert both.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (flush)        cnt_nxt = '0;
    else if (do_push) cnt_nxt = count + CW'(1);
    else if (do_pop)  cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= cnt_nxt;
      full  <= (cnt_nxt == FULL_CNT);
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/qed_i_cache.sv
// QED replay buffer: forwards and records original-phase fetches, replays them in duplicate phase.
module qed_i_cache
  import qed_i_cache_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter logic [INSTR_W-1:0] NOP = QED_NOP
) (
  input  logic clk,
  input  logic rst_n,
  qed_i_cache_if.slave bus
);
  logic [INSTR_W-1:0] fifo_dout;
  logic               push, pop, flush;
  qed_mode_e          mode;

  assign mode  = qed_mode_e'(bus.exec_dup);
  assign flush = !bus.stall && !bus.ena;
  assign push  = !bus.stall && bus.ena && (mode == MODE_ORIG) && bus.ifu_vld;
  assign pop   = !bus.stall && bus.ena && (mode == MODE_DUP);

  qed_sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.ifu_qed_instruction),
    .dout  (fifo_dout),
    .full  (bus.qic_full),
    .empty (bus.qic_empty),
    .count (bus.qic_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.qic_qimux_instruction <= NOP;
      bus.qic_vld_out           <= 1'b0;
      bus.qic_overflow          <= 1'b0;
    end else if (!bus.stall) begin
      if (!bus.ena || mode == MODE_ORIG) begin
        bus.qic_qimux_instruction <= bus.ifu_vld ? bus.ifu_qed_instruction : NOP;
        bus.qic_vld_out           <= bus.ifu_vld;
        // Dropped push: the word still reaches the decoder but is lost for replay.
        if (bus.ena && bus.ifu_vld && bus.qic_full) bus.qic_overflow <= 1'b1;
      end else begin
        bus.qic_qimux_instruction <= bus.qic_empty ? NOP : fifo_dout;
        bus.qic_vld_out           <= !bus.qic_empty;
      end
    end
  end
endmodule

// File: tb/tb_qed_i_cache.sv
// Directed bench for qed_i_cache: vector table plus hand sequences for overflow, wrap and reset.
module tb_qed_i_cache;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qed_i_cache_if #(.DEPTH(DEPTH)) bus ();
  qed_i_cache #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        rst_n, ena, dup, stall, vld;
    logic [31:0] instr;
    logic [31:0] eout;
    logic        evld;
    logic [4:0]  ecnt;
    logic        eempty, efull, eovf;
  } vec_t;

  vec_t tbl[64];
  int   ntbl = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] words[32];

  task automatic add(input logic r, e, d, s, v, input logic [31:0] ins,
                     input logic [31:0] eo, input logic ev, input logic [4:0] ec,
                     input logic ee, ef, eov);
    tbl[ntbl] = '{r, e, d, s, v, ins, eo, ev, ec, ee, ef, eov};
    ntbl++;
  endtask

  task automatic step(input logic r, e, d, s, v, input logic [31:0] ins);
    @(negedge clk);
    rst_n = r; bus.ena = e; bus.exec_dup = d; bus.stall = s;
    bus.ifu_vld = v; bus.ifu_qed_instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] eo, input logic ev,
                     input logic [4:0] ec, input logic ee, ef, eov);
    logic [40:0] act, exp;
    act = {bus.qic_qimux_instruction, bus.qic_vld_out, bus.qic_count,
           bus.qic_empty, bus.qic_full, bus.qic_overflow};
    exp = {eo, ev, ec, ee, ef, eov};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got out=%h vld=%b cnt=%0d empty=%b full=%b ovf=%b, want out=%h vld=%b cnt=%0d empty=%b full=%b ovf=%b",
               name, act[40:9], act[8], act[7:3], act[2], act[1], act[0],
               eo, ev, ec, ee, ef, eov);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.ena = 1'b0; bus.exec_dup = 1'b0; bus.stall = 1'b0;
    bus.ifu_vld = 1'b0; bus.ifu_qed_instruction = '0;

    // reset state
    add(0,0,0,0,0,32'h0,            NOPW,0,0,1,0,0);
    // original then replay
    add(1,1,0,0,1,32'h00100093,     32'h00100093,1,1,0,0,0);
    add(1,1,0,0,1,32'h00200113,     32'h00200113,1,2,0,0,0);
    add(1,1,0,0,1,32'h002081B3,     32'h002081B3,1,3,0,0,0);
    add(1,1,1,0,1,32'hDEADBEEF,     32'h00100093,1,2,0,0,0);
    add(1,1,1,0,0,32'h0,            32'h00200113,1,1,0,0,0);
    add(1,1,1,0,0,32'h0,            32'h002081B3,1,0,1,0,0);
    add(1,1,1,0,0,32'h0,            NOPW,0,0,1,0,0);
    // stall during replay with 4 entries
    for (int i = 0; i < 4; i++)
      add(1,1,0,0,1,32'h0000_1100 + i, 32'h0000_1100 + i,1,5'(i+1),0,0,0);
    add(1,1,1,0,0,32'h0,            32'h0000_1100,1,3,0,0,0);
    for (int i = 0; i < 3; i++)
      add(1,1,1,1,1,32'h0000_BAD0, 32'h0000_1100,1,3,0,0,0);
    add(1,1,1,0,0,32'h0,            32'h0000_1101,1,2,0,0,0);
    add(1,1,1,0,0,32'h0,            32'h0000_1102,1,1,0,0,0);
    add(1,1,1,0,0,32'h0,            32'h0000_1103,1,0,1,0,0);
    // passthrough / flush with 6 entries stored
    for (int i = 0; i < 6; i++)
      add(1,1,0,0,1,32'h0000_2200 + i, 32'h0000_2200 + i,1,5'(i+1),0,0,0);
    add(1,0,0,0,0,32'h0,            NOPW,0,0,1,0,0);
    add(1,0,0,0,1,32'h00000533,     32'h00000533,1,0,1,0,0);
    add(1,0,1,0,1,32'h00000633,     32'h00000633,1,0,1,0,0);

    for (int i = 0; i < ntbl; i++) begin
      step(tbl[i].rst_n, tbl[i].ena, tbl[i].dup, tbl[i].stall, tbl[i].vld, tbl[i].instr);
      chk($sformatf("vec%0d", i), tbl[i].eout, tbl[i].evld, tbl[i].ecnt,
          tbl[i].eempty, tbl[i].efull, tbl[i].eovf);
    end

    // full / overflow: 17 pushes, 17th forwarded but dropped
    for (int i = 0; i < 17; i++) begin
      words[i] = 32'hA000_0000 + 32'(i * 7);
      step(1,1,0,0,1,words[i]);
      chk($sformatf("fill%0d", i), words[i], 1, (i >= 15) ? 5'd16 : 5'(i+1),
          0, i >= 15, i == 16);
    end
    for (int i = 0; i < 16; i++) begin
      step(1,1,1,0,0,32'h0);
      chk($sformatf("drain%0d", i), words[i], 1, 5'(15-i), i == 15, 0, 1);
    end
    step(1,1,1,0,0,32'h0);
    chk("drain_end", NOPW, 0, 0, 1, 0, 1);
    step(1,0,0,0,0,32'h0);
    chk("ovf_sticky_flush", NOPW, 0, 0, 1, 0, 1);

    // wrap-around: pointers start at 0 after flush, second fill crosses 16
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      n = (pass == 0) ? 12 : 10;
      for (int i = 0; i < n; i++) begin
        words[i] = 32'hC000_0000 + 32'(pass * 256 + i);
        step(1,1,0,0,1,words[i]);
        chk($sformatf("wfill%0d_%0d", pass, i), words[i], 1, 5'(i+1), 0, 0, 1);
      end
      for (int i = 0; i < n; i++) begin
        step(1,1,1,0,0,32'h0);
        chk($sformatf("wdrain%0d_%0d", pass, i), words[i], 1, 5'(n-1-i), i == n-1, 0, 1);
      end
    end

    // reset mid-replay
    for (int i = 0; i < 5; i++) begin
      step(1,1,0,0,1,32'hE000_0000 + 32'(i));
      chk($sformatf("rfill%0d", i), 32'hE000_0000 + 32'(i), 1, 5'(i+1), 0, 0, 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1,1,1,0,0,32'h0);
      chk($sformatf("rpop%0d", i), 32'hE000_0000 + 32'(i), 1, 5'(4-i), 0, 0, 1);
    end
    step(0,1,1,0,0,32'h0);
    chk("rst_mid", NOPW, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1,1,1,0,0,32'h0);
      chk($sformatf("post_rst%0d", i), NOPW, 0, 0, 1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
